uart_tx_serializer: RTL and testbench
=====================================

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload bits per frame.
REQ-002 SHALL have parameter PRESCALE, default 16, UART_CLK cycles per serial bit; legal values are 2..63.
REQ-003 SHALL have port UART_CLK  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port RST  input  1  synchronous, active-low reset.
REQ-005 SHALL have port P_DATA  input  DATA_WIDTH  byte to transmit.
REQ-006 SHALL have port DATA_VALID  input  1  P_DATA offer; accepted only when READY=1.
REQ-007 SHALL have port PAR_EN  input  1  1 = parity bit appended.
REQ-008 SHALL have port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-009 SHALL have port TX_OUT  output  1  serial line; idle high.
REQ-010 SHALL have port BUSY  output  1  frame in progress, from start bit through stop bit.
REQ-011 SHALL have port READY  output  1  DATA_VALID is accepted this cycle.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY and STOP.
REQ-013 Accept SHALL occur when DATA_VALID=1 and READY=1 at a clock edge: P_DATA, PAR_EN and PAR_TYP are latched, and the parity bit is computed from the latched byte.
REQ-014 Accept in IDLE SHALL move the FSM to START on the same edge; TX_OUT=0 from the next cycle.
REQ-015 Each bit SHALL be driven for exactly PRESCALE cycles, using a bit-period counter of ceil(log2(PRESCALE)) bits that wraps from PRESCALE-1 to 0.
REQ-016 Bit order SHALL be: start(0), data LSB first, parity (if latched PAR_EN=1), stop(1).
REQ-017 Frame length SHALL be (DATA_WIDTH+3)*PRESCALE cycles with parity, and (DATA_WIDTH+2)*PRESCALE cycles without.
REQ-018 Parity bit SHALL equal XOR(data) when PAR_TYP=0 and ~XOR(data) when PAR_TYP=1.
REQ-019 Changes on P_DATA, PAR_EN or PAR_TYP after accept SHALL NOT affect the frame in flight.
REQ-020 TX_OUT SHALL be registered, glitch-free, and 1 in IDLE.
REQ-021 BUSY SHALL be registered: 1 in START, DATA, PARITY and STOP; 0 in IDLE.
REQ-022 At the last STOP cycle with no pending byte, the FSM SHALL go to IDLE, giving at least one idle-high cycle before the next start bit.
REQ-023 DATA_VALID while READY=0 SHALL be ignored; the offer is not stored.
REQ-024 DATA_VALID=1 with PAR_EN toggling between frames SHALL apply the per-frame latched value only.

Reset
REQ-025 RST=0 at an edge SHALL force: state IDLE, TX_OUT=1, BUSY=0, READY=1, counters 0, hold buffer empty.
REQ-026 Reset mid-frame SHALL abort the frame immediately; TX_OUT=1 from the next cycle, with no stop bit emitted.
REQ-027 RST SHALL take priority over DATA_VALID in the same cycle.

Configuration
REQ-028 Macro UART_TX_HOLD_BUF_EN SHALL compile in a one-entry hold buffer holding data, PAR_EN and PAR_TYP.
REQ-029 With UART_TX_HOLD_BUF_EN: READY = IDLE or buffer empty; an accept while BUSY fills the buffer.
REQ-030 With UART_TX_HOLD_BUF_EN, at the last STOP cycle with the buffer full, the FSM SHALL go directly to START, empty the buffer, and insert no idle cycle.
REQ-031 With UART_TX_HOLD_BUF_EN, if the last STOP cycle coincides with an accept into an empty buffer, that byte SHALL be sent next, back-to-back.
REQ-032 Without UART_TX_HOLD_BUF_EN: READY = (state==IDLE) and no buffer logic is synthesized.

Verification
REQ-033 PRESCALE=16, P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> TX_OUT = 0,1,0,1,0,0,1,0,1,0(parity),1, each 16 cycles; BUSY high 176 cycles.
REQ-034 P_DATA=0x01, PAR_EN=1, PAR_TYP=1 -> parity bit 0; with P_DATA=0x03 -> parity bit 1.
REQ-035 PAR_EN=0, P_DATA=0xFF -> 10-bit frame of 160 cycles; no parity slot.
REQ-036 DATA_VALID=1 held with 0x11 then 0x22 -> without macro: exactly one idle cycle between frames and the 0x22 offer ignored while BUSY; with macro: 0x22 start bit immediately follows the 0x11 stop bit.
REQ-037 RST=0 asserted at cycle 50 of a frame -> TX_OUT=1, BUSY=0 next cycle; a new accept afterwards sends a complete, correct frame.
REQ-038 P_DATA changed to 0x00 one cycle after accepting 0x5A -> line still carries 0x5A.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
// Define UART_TX_HOLD_BUF_EN to add a one-entry hold buffer for back-to-back frames.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 16
) (
    input  logic                  UART_CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY,
    output logic                  READY
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  r_tx;
    logic                  r_busy;

    state_t                w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic                  w_par_en_nxt;
    logic                  w_par_bit_nxt;
    logic                  w_tx_nxt;
    logic                  w_accept;
    logic                  w_bit_end;
    logic                  w_load;
    logic                  w_load_direct;
    logic [DATA_WIDTH-1:0] w_src_data;
    logic                  w_src_pen;
    logic                  w_src_ptyp;
    logic [CNT_W-1:0]      w_cnt_step;

`ifdef UART_TX_HOLD_BUF_EN
    logic                  r_hb_valid;
    logic [DATA_WIDTH-1:0] r_hb_data;
    logic                  r_hb_pen;
    logic                  r_hb_ptyp;

    assign READY      = (r_state == IDLE) || !r_hb_valid;
    assign w_src_data = w_load_direct ? P_DATA  : r_hb_data;
    assign w_src_pen  = w_load_direct ? PAR_EN  : r_hb_pen;
    assign w_src_ptyp = w_load_direct ? PAR_TYP : r_hb_ptyp;
`else
    assign READY      = (r_state == IDLE);
    assign w_src_data = P_DATA;
    assign w_src_pen  = PAR_EN;
    assign w_src_ptyp = PAR_TYP;
`endif

    assign w_accept   = DATA_VALID && READY;
    assign w_bit_end  = (r_cnt == CNT_LAST);
    assign w_cnt_step = w_bit_end ? '0 : r_cnt + 1'b1;
    assign w_shifted  = r_shift >> 1;

    assign TX_OUT = r_tx;
    assign BUSY   = r_busy;

    // Line level is computed for the next state so TX_OUT stays aligned with the FSM.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = '0;
        w_idx_nxt     = r_idx;
        w_shift_nxt   = r_shift;
        w_par_en_nxt  = r_par_en;
        w_par_bit_nxt = r_par_bit;
        w_tx_nxt      = r_tx;
        w_load        = 1'b0;
        w_load_direct = 1'b0;

        case (r_state)
            IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_accept) begin
                    w_load        = 1'b1;
                    w_load_direct = 1'b1;
                end
            end
            START: begin
                w_cnt_nxt = w_cnt_step;
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                    w_idx_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                end
            end
            DATA: begin
                w_cnt_nxt = w_cnt_step;
                if (w_bit_end) begin
                    w_shift_nxt = w_shifted;
                    if (r_idx == IDX_LAST) begin
                        if (r_par_en) begin
                            w_state_nxt = PARITY;
                            w_tx_nxt    = r_par_bit;
                        end else begin
                            w_state_nxt = STOP;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                        w_tx_nxt  = w_shifted[0];
                    end
                end
            end
            PARITY: begin
                w_cnt_nxt = w_cnt_step;
                if (w_bit_end) begin
                    w_state_nxt = STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
            STOP: begin
                w_cnt_nxt = w_cnt_step;
                if (w_bit_end) begin
`ifdef UART_TX_HOLD_BUF_EN
                    if (r_hb_valid) begin
                        w_load = 1'b1;
                    end else if (w_accept) begin
                        w_load        = 1'b1;
                        w_load_direct = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_tx_nxt    = 1'b1;
                    end
`else
                    w_state_nxt = IDLE;
                    w_tx_nxt    = 1'b1;
`endif
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase

        if (w_load) begin
            w_state_nxt   = START;
            w_cnt_nxt     = '0;
            w_tx_nxt      = 1'b0;
            w_shift_nxt   = w_src_data;
            w_par_en_nxt  = w_src_pen;
            w_par_bit_nxt = (^w_src_data) ^ w_src_ptyp;
        end
    end

    always_ff @(posedge UART_CLK) begin
        if (!RST) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_par_en  <= w_par_en_nxt;
            r_par_bit <= w_par_bit_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= (w_state_nxt != IDLE);
        end
    end

`ifdef UART_TX_HOLD_BUF_EN
    // Offers that are not loaded straight into the shifter park here until the current stop bit ends.
    always_ff @(posedge UART_CLK) begin
        if (!RST) begin
            r_hb_valid <= 1'b0;
            r_hb_data  <= '0;
            r_hb_pen   <= 1'b0;
            r_hb_ptyp  <= 1'b0;
        end else begin
            if (w_load && !w_load_direct) begin
                r_hb_valid <= 1'b0;
            end
            if (w_accept && !w_load_direct) begin
                r_hb_valid <= 1'b1;
                r_hb_data  <= P_DATA;
                r_hb_pen   <= PAR_EN;
                r_hb_ptyp  <= PAR_TYP;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer at DATA_WIDTH=8, PRESCALE=16.
module tb_uart_tx_serializer;

    localparam int P = 16;
    localparam int W = 8;

    logic       UART_CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = '0;
    logic       DATA_VALID = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       TX_OUT, BUSY, READY;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       pen;
        logic       ptyp;
    } item_t;

    item_t sb[$];

    always #5 UART_CLK = ~UART_CLK;

    uart_tx_serializer #(.DATA_WIDTH(W), .PRESCALE(P)) dut (
        .UART_CLK  (UART_CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .DATA_VALID(DATA_VALID),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .TX_OUT    (TX_OUT),
        .BUSY      (BUSY),
        .READY     (READY)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    function automatic int frame_bits(input item_t it);
        return it.pen ? W + 3 : W + 2;
    endfunction

    function automatic logic [10:0] model(input item_t it);
        logic [10:0] v;
        v = '0;
        for (int i = 0; i < W; i++) v[1 + i] = it.d[i];
        if (it.pen) begin
            v[W + 1] = (^it.d) ^ it.ptyp;
            v[W + 2] = 1'b1;
        end else begin
            v[W + 1] = 1'b1;
        end
        return v;
    endfunction

    // Records one frame starting at the current falling edge; ends on the edge after the frame.
    task automatic grab(input int nb, output logic [10:0] bits, output int glitch,
                        output int busy_cyc, output int ready_cyc);
        bits = '0; glitch = 0; busy_cyc = 0; ready_cyc = 0;
        for (int i = 0; i < nb * P; i++) begin
            if (i % P == 0) bits[i / P] = TX_OUT;
            else if (TX_OUT !== bits[i / P]) glitch++;
            if (BUSY === 1'b1) busy_cyc++;
            if (READY === 1'b1) ready_cyc++;
            @(negedge UART_CLK);
        end
    endtask

    task automatic offer(input logic [7:0] d, input logic pen, input logic ptyp);
        item_t it;
        it.d = d; it.pen = pen; it.ptyp = ptyp;
        P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; DATA_VALID = 1'b1;
        sb.push_back(it);
        @(negedge UART_CLK);
        DATA_VALID = 1'b0;
        P_DATA = 8'($urandom);
        PAR_EN = 1'($urandom);
        PAR_TYP = 1'($urandom);
    endtask

    task automatic test_reset;
        RST = 1'b0;
        repeat (3) @(negedge UART_CLK);
        checks++; if (TX_OUT !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", TX_OUT); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        checks++; if (READY !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", READY); end
        RST = 1'b1;
        repeat (2) @(negedge UART_CLK);
        checks++; if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: got tx=%b busy=%b want tx=1 busy=0", TX_OUT, BUSY);
        end
    endtask

    task automatic test_frames;
        item_t tbl[6];
        item_t it;
        logic [10:0] bits;
        int g, b, r, rdy_exp;
        tbl[0] = '{d: 8'hA5, pen: 1'b1, ptyp: 1'b0};
        tbl[1] = '{d: 8'h01, pen: 1'b1, ptyp: 1'b1};
        tbl[2] = '{d: 8'h03, pen: 1'b1, ptyp: 1'b1};
        tbl[3] = '{d: 8'hFF, pen: 1'b0, ptyp: 1'b0};
        tbl[4] = '{d: 8'($urandom), pen: 1'b1, ptyp: 1'b0};
        tbl[5] = '{d: 8'($urandom), pen: 1'b0, ptyp: 1'b1};
        for (int k = 0; k < 6; k++) begin
            offer(tbl[k].d, tbl[k].pen, tbl[k].ptyp);
            it = sb.pop_front();
            grab(frame_bits(it), bits, g, b, r);
`ifdef UART_TX_HOLD_BUF_EN
            rdy_exp = frame_bits(it) * P;
`else
            rdy_exp = 0;
`endif
            checks++; if (bits !== model(it)) begin errors++; $display("FAIL frame_bits[%0d]: got %b want %b", k, bits, model(it)); end
            checks++; if (g != 0) begin errors++; $display("FAIL bit_width[%0d]: got %0d unstable cycles want 0", k, g); end
            checks++; if (b != frame_bits(it) * P) begin errors++; $display("FAIL busy_len[%0d]: got %0d want %0d", k, b, frame_bits(it) * P); end
            checks++; if (r != rdy_exp) begin errors++; $display("FAIL ready_in_frame[%0d]: got %0d want %0d", k, r, rdy_exp); end
            checks++; if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
                errors++; $display("FAIL frame_end[%0d]: got tx=%b busy=%b want tx=1 busy=0", k, TX_OUT, BUSY);
            end
            @(negedge UART_CLK);
        end
    endtask

    task automatic test_data_change;
        item_t it;
        logic [10:0] bits;
        int g, b, r;
        offer(8'h5A, 1'b1, 1'b0);
        P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b1;
        it = sb.pop_front();
        grab(frame_bits(it), bits, g, b, r);
        checks++; if (bits !== model(it)) begin errors++; $display("FAIL latched_data: got %b want %b", bits, model(it)); end
        checks++; if (g != 0 || b != 11 * P) begin errors++; $display("FAIL latched_timing: got glitch=%0d busy=%0d want 0 %0d", g, b, 11 * P); end
        @(negedge UART_CLK);
    endtask

`ifndef UART_TX_HOLD_BUF_EN
    task automatic test_ignore_busy;
        item_t it;
        logic [10:0] bits;
        int g, b, r;
        offer(8'h3C, 1'b1, 1'b1);
        fork
            begin
                repeat (20) @(negedge UART_CLK);
                P_DATA = 8'h77; DATA_VALID = 1'b1;
                repeat (5) @(negedge UART_CLK);
                DATA_VALID = 1'b0;
            end
        join_none
        it = sb.pop_front();
        grab(frame_bits(it), bits, g, b, r);
        checks++; if (bits !== model(it)) begin errors++; $display("FAIL busy_offer_frame: got %b want %b", bits, model(it)); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
                errors++; $display("FAIL busy_offer_dropped[%0d]: got tx=%b busy=%b want tx=1 busy=0", i, TX_OUT, BUSY);
            end
            @(negedge UART_CLK);
        end
    endtask
`endif

    task automatic test_back_to_back;
        item_t it;
        logic [10:0] bits;
        int g, b, r, drop;
        it = '{d: 8'h11, pen: 1'b1, ptyp: 1'b0};
        sb.push_back(it);
        P_DATA = 8'h11; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
        @(negedge UART_CLK);
        it = '{d: 8'h22, pen: 1'b0, ptyp: 1'b1};
        sb.push_back(it);
        P_DATA = 8'h22; PAR_EN = 1'b0; PAR_TYP = 1'b1;
`ifdef UART_TX_HOLD_BUF_EN
        drop = 1;
`else
        drop = 11 * P + 1;
`endif
        fork
            begin
                repeat (drop) @(negedge UART_CLK);
                DATA_VALID = 1'b0;
            end
        join_none
        it = sb.pop_front();
        grab(frame_bits(it), bits, g, b, r);
        checks++; if (bits !== model(it) || g != 0) begin errors++; $display("FAIL b2b_first: got %b glitch=%0d want %b glitch=0", bits, g, model(it)); end
`ifndef UART_TX_HOLD_BUF_EN
        checks++; if (TX_OUT !== 1'b1 || BUSY !== 1'b0 || READY !== 1'b1) begin
            errors++; $display("FAIL b2b_idle_gap: got tx=%b busy=%b ready=%b want 1 0 1", TX_OUT, BUSY, READY);
        end
        @(negedge UART_CLK);
`endif
        it = sb.pop_front();
        grab(frame_bits(it), bits, g, b, r);
        checks++; if (bits !== model(it) || g != 0) begin errors++; $display("FAIL b2b_second: got %b glitch=%0d want %b glitch=0", bits, g, model(it)); end
        checks++; if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
            errors++; $display("FAIL b2b_end: got tx=%b busy=%b want tx=1 busy=0", TX_OUT, BUSY);
        end
        @(negedge UART_CLK);
    endtask

    task automatic test_reset_mid_frame;
        item_t it;
        logic [10:0] bits;
        int g, b, r;
        offer(8'hC3, 1'b1, 1'b1);
        repeat (49) @(negedge UART_CLK);
        RST = 1'b0; DATA_VALID = 1'b1; P_DATA = 8'h00;
        @(negedge UART_CLK);
        checks++; if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
            errors++; $display("FAIL abort_line: got tx=%b busy=%b want tx=1 busy=0", TX_OUT, BUSY);
        end
        checks++; if (READY !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", READY); end
        @(negedge UART_CLK);
        checks++; if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
            errors++; $display("FAIL reset_priority: got tx=%b busy=%b want tx=1 busy=0", TX_OUT, BUSY);
        end
        RST = 1'b1; DATA_VALID = 1'b0;
        void'(sb.pop_front());
        @(negedge UART_CLK);
        offer(8'h96, 1'b1, 1'b0);
        it = sb.pop_front();
        grab(frame_bits(it), bits, g, b, r);
        checks++; if (bits !== model(it)) begin errors++; $display("FAIL post_reset_frame: got %b want %b", bits, model(it)); end
        checks++; if (g != 0 || b != 11 * P) begin errors++; $display("FAIL post_reset_timing: got glitch=%0d busy=%0d want 0 %0d", g, b, 11 * P); end
        @(negedge UART_CLK);
    endtask

    initial begin
        test_reset();
        test_frames();
        test_data_change();
`ifndef UART_TX_HOLD_BUF_EN
        test_ignore_busy();
`endif
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
